// File: rtl/pc_redirect_ctl.sv
// rtl/pc_redirect_ctl.sv - arbitrates trap/jalr/mispredict/jal redirects into the fetch PC.
// Define PC_REDIR_CNT_EN to add saturating redirect/hold event counters.
module pc_redirect_ctl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            trap_taken,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_addr,
  input  logic            pr_miss,
  input  logic [XLEN-1:0] br_addr,
  input  logic            jal_taken,
  input  logic [XLEN-1:0] jal_addr,
  input  logic            if_busy,
  input  logic            if_rsp_vld,
  input  logic            pipe_stall,
  output logic            redir_vld,
  output logic [XLEN-1:0] redir_addr,
  output logic            pc_stall,
  output logic            flush_if,
  output logic            flush_id,
  output logic            drop_rsp,
  output logic            busy
`ifdef PC_REDIR_CNT_EN
  ,
  output logic [31:0]     redir_cnt,
  output logic [31:0]     hold_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [XLEN-1:0] JALR_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;

  logic            req_any;
  logic            win_jal;
  logic [XLEN-1:0] req_tgt;
  logic            pc_free;

  logic            redir_c;
  logic [XLEN-1:0] addr_c;
  logic            stall_c;
  logic            flush_if_c;
  logic            flush_id_c;
  logic            drop_c;

  assign req_any = trap_taken | jalr_taken | pr_miss | jal_taken;
  assign win_jal = ~trap_taken & ~jalr_taken & ~pr_miss & jal_taken;
  assign pc_free = ~if_busy & ~pipe_stall;

  always_comb begin
    req_tgt = jal_addr;
    if (trap_taken)      req_tgt = trap_addr;
    else if (jalr_taken) req_tgt = jalr_addr & JALR_MASK;
    else if (pr_miss)    req_tgt = br_addr;
  end

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    redir_c     = 1'b0;
    addr_c      = '0;
    stall_c     = 1'b0;
    flush_if_c  = 1'b0;
    flush_id_c  = 1'b0;
    drop_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_c = if_busy | pipe_stall;
        if (req_any) begin
          flush_if_c = 1'b1;
          flush_id_c = ~win_jal;
          if (pc_free) begin
            redir_c = 1'b1;
            addr_c  = req_tgt;
          end else begin
            pend_addr_d = req_tgt;
            state_d     = if_busy ? ST_DRAIN : ST_HOLD;
          end
        end
      end
      ST_DRAIN: begin
        // Only a trap may retarget while pending; other sources are already flushed.
        stall_c = 1'b1;
        drop_c  = if_rsp_vld;
        if (trap_taken) begin
          flush_if_c  = 1'b1;
          flush_id_c  = 1'b1;
          pend_addr_d = trap_addr;
        end
        if (if_rsp_vld) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (trap_taken) begin
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
        end
        if (pc_free) begin
          redir_c = 1'b1;
          addr_c  = trap_taken ? trap_addr : pend_addr_q;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          if (trap_taken) pend_addr_d = trap_addr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though requests may still toggle.
  assign redir_vld  = clr_n & redir_c;
  assign redir_addr = clr_n ? addr_c : '0;
  assign pc_stall   = clr_n & stall_c;
  assign flush_if   = clr_n & flush_if_c;
  assign flush_id   = clr_n & flush_id_c;
  assign drop_rsp   = clr_n & drop_c;
  assign busy       = clr_n & (state_q != ST_IDLE);

`ifdef PC_REDIR_CNT_EN
  logic [31:0] redir_cnt_q, hold_cnt_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      redir_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      if (redir_vld && (redir_cnt_q != 32'hFFFF_FFFF)) redir_cnt_q <= redir_cnt_q + 32'd1;
      if (busy && (hold_cnt_q != 32'hFFFF_FFFF))       hold_cnt_q  <= hold_cnt_q + 32'd1;
    end
  end

  assign redir_cnt = redir_cnt_q;
  assign hold_cnt  = hold_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctl.sv
// tb/tb_pc_redirect_ctl.sv - directed and random checks of pc_redirect_ctl against a rule-level model.
module tb_pc_redirect_ctl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            clr_n;
  logic            trap_taken, jalr_taken, pr_miss, jal_taken;
  logic [XLEN-1:0] trap_addr, jalr_addr, br_addr, jal_addr;
  logic            if_busy, if_rsp_vld, pipe_stall;
  logic            redir_vld, pc_stall, flush_if, flush_id, drop_rsp, busy;
  logic [XLEN-1:0] redir_addr;
`ifdef PC_REDIR_CNT_EN
  logic [31:0]     redir_cnt, hold_cnt;
`endif

  always #5 clk = ~clk;

  pc_redirect_ctl #(.XLEN(XLEN)) dut (
    .clk(clk), .clr_n(clr_n),
    .trap_taken(trap_taken), .trap_addr(trap_addr),
    .jalr_taken(jalr_taken), .jalr_addr(jalr_addr),
    .pr_miss(pr_miss), .br_addr(br_addr),
    .jal_taken(jal_taken), .jal_addr(jal_addr),
    .if_busy(if_busy), .if_rsp_vld(if_rsp_vld), .pipe_stall(pipe_stall),
    .redir_vld(redir_vld), .redir_addr(redir_addr), .pc_stall(pc_stall),
    .flush_if(flush_if), .flush_id(flush_id), .drop_rsp(drop_rsp), .busy(busy)
`ifdef PC_REDIR_CNT_EN
    , .redir_cnt(redir_cnt), .hold_cnt(hold_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: at most one pending target, plus whether the stale fetch still has to come back.
  logic [63:0] pend_q[$];
  bit          await_rsp;
  logic [63:0] nxt_q[$];
  bit          nxt_await;
  int unsigned m_rcnt, m_hcnt;
  logic        e_redir, e_stall, e_fif, e_fid, e_drop, e_busy;
  logic [63:0] e_addr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_eval();
    logic [63:0] tgt;
    bit free;
    e_redir = 0; e_stall = 0; e_fif = 0; e_fid = 0; e_drop = 0; e_busy = 0; e_addr = '0;
    if (!clr_n) begin
      pend_q.delete(); await_rsp = 0; m_rcnt = 0; m_hcnt = 0;
      nxt_q.delete(); nxt_await = 0;
      return;
    end
    nxt_q = pend_q;
    nxt_await = await_rsp;
    free = !if_busy && !pipe_stall;
    if (trap_taken)      tgt = trap_addr;
    else if (jalr_taken) tgt = jalr_addr - 64'(jalr_addr % 2);
    else if (pr_miss)    tgt = br_addr;
    else                 tgt = jal_addr;
    if (pend_q.size() == 0) begin
      e_stall = if_busy || pipe_stall;
      if (trap_taken || jalr_taken || pr_miss || jal_taken) begin
        e_fif = 1;
        e_fid = trap_taken || jalr_taken || pr_miss;
        if (free) begin
          e_redir = 1;
          e_addr = tgt;
        end else begin
          nxt_q = '{tgt};
          nxt_await = if_busy;
        end
      end
    end else begin
      e_busy = 1;
      e_fif = trap_taken;
      e_fid = trap_taken;
      if (await_rsp) begin
        e_stall = 1;
        e_drop = if_rsp_vld;
        if (trap_taken) nxt_q = '{trap_addr};
        if (if_rsp_vld) nxt_await = 0;
      end else if (free) begin
        e_redir = 1;
        e_addr = trap_taken ? trap_addr : pend_q[0];
        nxt_q.delete();
      end else begin
        e_stall = 1;
        if (trap_taken) nxt_q = '{trap_addr};
      end
    end
  endtask

  task automatic settle_check(input string tag);
    #2;
    model_eval();
    chk({tag, ":redir_vld"}, 64'(redir_vld), 64'(e_redir));
    chk({tag, ":redir_addr"}, redir_addr, e_addr);
    chk({tag, ":pc_stall"}, 64'(pc_stall), 64'(e_stall));
    chk({tag, ":flush_if"}, 64'(flush_if), 64'(e_fif));
    chk({tag, ":flush_id"}, 64'(flush_id), 64'(e_fid));
    chk({tag, ":drop_rsp"}, 64'(drop_rsp), 64'(e_drop));
    chk({tag, ":busy"}, 64'(busy), 64'(e_busy));
    chk({tag, ":vld_and_stall"}, 64'(redir_vld & pc_stall), 64'd0);
`ifdef PC_REDIR_CNT_EN
    chk({tag, ":redir_cnt"}, 64'(redir_cnt), 64'(m_rcnt));
    chk({tag, ":hold_cnt"}, 64'(hold_cnt), 64'(m_hcnt));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (clr_n) begin
      pend_q = nxt_q;
      await_rsp = nxt_await;
      if (e_redir && m_rcnt != 32'hFFFF_FFFF) m_rcnt++;
      if (e_busy && m_hcnt != 32'hFFFF_FFFF) m_hcnt++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    trap_taken = 0; jalr_taken = 0; pr_miss = 0; jal_taken = 0;
    if_busy = 0; if_rsp_vld = 0; pipe_stall = 0;
  endtask

  initial begin
    clr_n = 0;
    trap_addr = 64'h8000_0100; jalr_addr = 64'h8000_1235;
    br_addr = 64'h8000_0400; jal_addr = 64'h8000_2000;
    quiet();
    @(negedge clk);
    settle_check("reset");
    chk("reset_busy", 64'(busy), 64'd0);
    advance();
    clr_n = 1;
    settle_check("idle");
    advance();

    jalr_taken = 1; jalr_addr = 64'h8000_1235;
    settle_check("jalr_zero_lat");
    chk("jalr_vld", 64'(redir_vld), 64'd1);
    chk("jalr_addr_bit0", redir_addr, 64'h8000_1234);
    chk("jalr_flush_id", 64'(flush_id), 64'd1);
    advance();

    trap_taken = 1; jalr_taken = 1; jal_taken = 1;
    trap_addr = 64'h8000_0100; jalr_addr = 64'h8000_4000; jal_addr = 64'h8000_2000;
    settle_check("prio");
    chk("prio_addr", redir_addr, 64'h8000_0100);
    advance();

    quiet(); jal_taken = 1; if_busy = 1;
    settle_check("jal_c0");
    chk("jal_c0_fif", 64'(flush_if), 64'd1);
    chk("jal_c0_fid", 64'(flush_id), 64'd0);
    advance();
    jal_taken = 0;
    settle_check("jal_c1");
    chk("jal_c1_busy", 64'(busy), 64'd1);
    advance();
    if_rsp_vld = 1;
    settle_check("jal_c2");
    chk("jal_c2_drop", 64'(drop_rsp), 64'd1);
    advance();
    quiet();
    settle_check("jal_c3");
    chk("jal_c3_vld", 64'(redir_vld), 64'd1);
    chk("jal_c3_addr", redir_addr, 64'h8000_2000);
    advance();
    settle_check("jal_c4");
    chk("jal_c4_busy", 64'(busy), 64'd0);
    advance();

    pr_miss = 1; br_addr = 64'h8000_0400; pipe_stall = 1;
    settle_check("pr_c0");
    chk("pr_c0_stall", 64'(pc_stall), 64'd1);
    advance();
    pr_miss = 0;
    settle_check("pr_c1");
    advance();
    pipe_stall = 0;
    settle_check("pr_c2");
    chk("pr_c2_addr", redir_addr, 64'h8000_0400);
    advance();

    pr_miss = 1; pipe_stall = 1;
    settle_check("hold_enter");
    advance();
    pr_miss = 0; jalr_taken = 1; jalr_addr = 64'h8000_9000;
    settle_check("hold_jalr_ignored");
    chk("hold_jalr_fid", 64'(flush_id), 64'd0);
    advance();
    jalr_taken = 0; trap_taken = 1; trap_addr = 64'h8000_0100;
    settle_check("hold_trap");
    advance();
    trap_taken = 0; pipe_stall = 0;
    settle_check("hold_issue");
    chk("hold_issue_addr", redir_addr, 64'h8000_0100);
    advance();

    pr_miss = 1; br_addr = 64'h8000_0400; pipe_stall = 1;
    settle_check("bypass_enter");
    advance();
    pr_miss = 0; pipe_stall = 0; trap_taken = 1; trap_addr = 64'h8000_0C00;
    settle_check("bypass_issue");
    chk("bypass_addr", redir_addr, 64'h8000_0C00);
    advance();

    quiet(); jal_taken = 1; if_busy = 1;
    settle_check("rst_enter");
    advance();
    jal_taken = 0; if_rsp_vld = 1; clr_n = 0;
    settle_check("rst_mid");
    chk("rst_mid_drop", 64'(drop_rsp), 64'd0);
    advance();
    clr_n = 1; if_busy = 0;
    settle_check("rst_rel0");
    chk("rst_rel_vld", 64'(redir_vld), 64'd0);
    advance();
    if_rsp_vld = 0;
    settle_check("rst_rel1");
    advance();

    for (int i = 0; i < 3000; i++) begin
      clr_n      = ($urandom_range(199) != 0);
      trap_taken = ($urandom_range(9) == 0);
      jalr_taken = ($urandom_range(7) == 0);
      pr_miss    = ($urandom_range(7) == 0);
      jal_taken  = ($urandom_range(5) == 0);
      trap_addr  = {$urandom(), $urandom()};
      jalr_addr  = {$urandom(), $urandom()};
      br_addr    = {$urandom(), $urandom()};
      jal_addr   = {$urandom(), $urandom()};
      if_busy    = ($urandom_range(2) == 0);
      if_rsp_vld = ($urandom_range(2) == 0);
      pipe_stall = ($urandom_range(3) == 0);
      settle_check("rand");
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctl.md
Name: pc_redirect_ctl

Overview:
Arbitrates every control-flow redirect aimed at the fetch PC register and sequences each one safely into that register. Sources are traps, jalr, branch mispredicts and jal. Sits between the EX/ID/CSR redirect sources and the PC register, next to the icache fetch port. Generates the PC load/stall, the IF/ID flushes, and drops the stale icache response when a redirect lands while a fetch is outstanding.

Parameters:
XLEN, 64, address width of the PC and of all redirect targets.

Ports:
clk  input  1  clock
clr_n  input  1  asynchronous active-low reset
trap_taken  input  1  trap/interrupt redirect request (CSR unit)
trap_addr  input  XLEN  trap target
jalr_taken  input  1  jalr resolved in EX
jalr_addr  input  XLEN  jalr target (bit 0 not yet cleared)
pr_miss  input  1  branch mispredict resolved in EX
br_addr  input  XLEN  corrected branch target
jal_taken  input  1  jal decoded in ID
jal_addr  input  XLEN  jal target
if_busy  input  1  icache fetch outstanding, PC must not change
if_rsp_vld  input  1  icache response valid this cycle
pipe_stall  input  1  downstream hazard stall
redir_vld  output  1  PC register loads redir_addr this cycle
redir_addr  output  XLEN  redirect target
pc_stall  output  1  PC register hold
flush_if  output  1  kill IF/ID register contents
flush_id  output  1  kill ID/EX register contents
drop_rsp  output  1  discard the current icache response
busy  output  1  a redirect is pending (state != IDLE)

Behaviour:
- Reset (clr_n low, async): state IDLE, pending addr/valid cleared, all outputs 0.
- Reset mid-operation discards any pending redirect. No redirect is issued after release.
- Priority: trap > jalr > pr_miss > jal. Only the winner is used; the rest are ignored that cycle.
- Target: jalr target has bit 0 forced to 0. All other targets pass through unchanged.
- Flush on acceptance, combinational in the same cycle:
  - trap/jalr/pr_miss assert flush_if=flush_id=1.
  - jal asserts flush_if=1 only.
- FSM states: IDLE, DRAIN, HOLD.
- IDLE with a request:
  - !if_busy & !pipe_stall: redir_vld=1 in the same cycle (zero latency); stay IDLE.
  - if_busy: latch target; go DRAIN.
  - !if_busy & pipe_stall: latch target; go HOLD.
- IDLE with no request: pc_stall = if_busy | pipe_stall; redir_vld=0.
- DRAIN:
  - drop_rsp = if_rsp_vld.
  - On if_rsp_vld, go HOLD next cycle. The dropped response is never forwarded.
- HOLD:
  - When !if_busy & !pipe_stall: redir_vld=1, redir_addr = pending; go IDLE.
  - Otherwise wait.
- In DRAIN/HOLD: pc_stall = !redir_vld. busy=1.
- Requests while pending (DRAIN/HOLD):
  - jalr/pr_miss/jal are ignored; they come from already-flushed instructions.
  - trap_taken overwrites the pending target and reasserts flush_if/flush_id; state is unchanged.
  - A trap in the HOLD issue cycle is bypassed: redir_addr = trap_addr.
- redir_vld and pc_stall are never both 1.
- redir_addr is 0 whenever redir_vld=0.

Optional Feature:
- Macro: PC_REDIR_CNT_EN.
- When defined, adds two outputs:
  - redir_cnt[31:0]: increments per redir_vld cycle.
  - hold_cnt[31:0]: increments per cycle with busy=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- IDLE, jalr_taken=1 with jalr_addr=0x80001235, no stalls -> same cycle: redir_vld=1, redir_addr=0x80001234, flush_if=flush_id=1, pc_stall=0, busy=0.
- trap 0x80000100, jalr 0x80004000 and jal 0x80002000 asserted together -> redir_addr=0x80000100, flush_if=flush_id=1.
- jal 0x80002000 at cycle 0 with if_busy=1 for cycles 0-2 and if_rsp_vld at cycle 2 -> expected:
  - flush_if=1, flush_id=0 at cycle 0;
  - drop_rsp=1 at cycle 2;
  - redir_vld=1 with 0x80002000 at cycle 3;
  - busy=1 in cycles 1-3, then 0.
- pr_miss with br_addr=0x80000400 and pipe_stall=1 for cycles 0-1 -> HOLD, pc_stall=1; redir_vld=1 at cycle 2 with 0x80000400.
- In HOLD (pending 0x80000400): jalr 0x80009000 -> ignored. Then trap 0x80000100 -> pending replaced, issued redir_addr=0x80000100.
- clr_n pulsed low during DRAIN -> immediately IDLE with all outputs 0. No redir_vld and no drop_rsp after release.
